// File: rtl/game_pkg.sv
// game_pkg
// Shared types and constants for the space_invaders game sequencer.
//   game_state_t : 2-bit state encoding exported on game_ctrl.state
//   SCORE_MAX    : BCD ceiling of the 2-digit score (99)
//   SPEED_MAX    : ceiling of the alien step-rate index (7)
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam logic [7:0] SCORE_MAX = 8'h99;
  localparam logic [2:0] SPEED_MAX = 3'd7;

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter
// Two-digit BCD up-counter used for the player score. Counting stops at 99.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset, count returns to 00
//   clr   : synchronous clear to 00, wins over inc
//   inc   : add one to the count this cycle
//   count : {tens, ones} BCD value
module bcd_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  // The count is held in BCD directly so the seven-segment drivers never need
  // a binary-to-decimal conversion. A carry out of the ones digit bumps the
  // tens digit; once the value reaches 99 further increments are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (inc && (count != SCORE_MAX)) begin
      if (count[3:0] == 4'd9) begin
        count <= {count[7:4] + 4'd1, 4'd0};
      end else begin
        count <= {count[7:4], count[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
// Top-level game sequencer: owns the game state, lives, score and alien speed,
// gates the world update and requests entity re-initialisation.
// Parameters:
//   LIVES_INIT : lives loaded at game start (1..3)
//   HIT_FRAMES : frames the world stays frozen after the player is hit (>=1)
// Ports:
//   clk, rst       : system clock, asynchronous active-high reset
//   frame_tick     : one pulse per VGA frame
//   btn_shoot      : debounced level, rising edge starts / leaves a game
//   btn_rst        : debounced level, soft restart back to IDLE
//   alien_hit      : pulse, player bullet killed an alien
//   player_hit     : pulse, alien bullet hit the player
//   aliens_landed  : pulse, aliens reached the player row
//   aliens_cleared : pulse, last alien of the wave died
//   state          : current game_state_t encoding
//   play_en        : world may move and shoot
//   world_rst      : one-cycle pulse, entities reinitialise
//   lives          : remaining lives
//   score_bcd      : {tens, ones} BCD score
//   alien_speed    : alien step-rate index
// Build option:
//   WAVE_SPEEDUP_EN : when defined, alien_speed climbs by one on every cleared
//                     wave (saturating at 7); otherwise it is tied to 0.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int HIT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_shoot,
  input  logic       btn_rst,
  input  logic       alien_hit,
  input  logic       player_hit,
  input  logic       aliens_landed,
  input  logic       aliens_cleared,
  output logic [1:0] state,
  output logic       play_en,
  output logic       world_rst,
  output logic [1:0] lives,
  output logic [7:0] score_bcd,
  output logic [2:0] alien_speed
);

  localparam int FW = $clog2(HIT_FRAMES + 1);

  game_state_t   cur_state;
  logic [FW-1:0] freeze_cnt;
  logic          shoot_d;
  logic          shoot_edge;
  logic          start_game;
  logic          goes_over;
  logic          clear_ok;
  logic          game_clr;
  logic          score_inc;

  // A game starts only from IDLE on a fresh shoot press, and a soft restart
  // suppresses it. A PLAY cycle ends the game when the aliens land or the
  // last life is lost; a wave clear in that same cycle is dropped so the world
  // is not rebuilt underneath the game-over screen. Score and speed are
  // cleared both by a new game and by a soft restart.
  assign shoot_edge = btn_shoot & ~shoot_d;
  assign start_game = ~btn_rst & (cur_state == IDLE) & shoot_edge;
  assign goes_over  = aliens_landed | (player_hit & (lives == 2'd1));
  assign clear_ok   = ~btn_rst & (cur_state == PLAY) & aliens_cleared & ~goes_over;
  assign game_clr   = btn_rst | start_game;
  assign score_inc  = ~btn_rst & (cur_state == PLAY) & alien_hit;

  assign state = cur_state;

  // Delay register for the shoot button so a held button starts one game,
  // not one per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_d <= 1'b0;
    end else begin
      shoot_d <= btn_shoot;
    end
  end

  // Main sequencer. play_en is registered alongside the next state so it is
  // high exactly while state reads PLAY. world_rst defaults low every cycle
  // so any request is a single-cycle pulse. The freeze counter is only
  // stepped by frame ticks, so the HIT pause lasts a fixed number of frames
  // regardless of clock rate. Soft restart overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= IDLE;
      play_en    <= 1'b0;
      world_rst  <= 1'b0;
      lives      <= 2'(LIVES_INIT);
      freeze_cnt <= '0;
    end else begin
      world_rst <= 1'b0;
      if (btn_rst) begin
        cur_state  <= IDLE;
        play_en    <= 1'b0;
        lives      <= 2'(LIVES_INIT);
        freeze_cnt <= '0;
      end else begin
        case (cur_state)
          IDLE: begin
            if (start_game) begin
              cur_state <= PLAY;
              play_en   <= 1'b1;
              world_rst <= 1'b1;
              lives     <= 2'(LIVES_INIT);
            end
          end
          PLAY: begin
            if (aliens_landed) begin
              lives     <= 2'd0;
              cur_state <= OVER;
              play_en   <= 1'b0;
            end else if (player_hit) begin
              if (lives == 2'd1) begin
                lives     <= 2'd0;
                cur_state <= OVER;
              end else begin
                lives      <= lives - 2'd1;
                freeze_cnt <= FW'(HIT_FRAMES);
                cur_state  <= HIT;
              end
              play_en <= 1'b0;
            end
            if (clear_ok) begin
              world_rst <= 1'b1;
            end
          end
          HIT: begin
            if (frame_tick) begin
              freeze_cnt <= freeze_cnt - FW'(1);
              if (freeze_cnt == FW'(1)) begin
                cur_state <= PLAY;
                play_en   <= 1'b1;
              end
            end
          end
          OVER: begin
            if (shoot_edge) begin
              cur_state <= IDLE;
            end
          end
          default: begin
            cur_state <= IDLE;
            play_en   <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_counter u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (game_clr),
    .inc   (score_inc),
    .count (score_bcd)
  );

`ifdef WAVE_SPEEDUP_EN
  logic [2:0] speed_q;

  // Each accepted wave clear makes the next wave faster, up to SPEED_MAX.
  // A new game or a soft restart drops back to the slowest rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q <= 3'd0;
    end else if (game_clr) begin
      speed_q <= 3'd0;
    end else if (clear_ok && (speed_q != SPEED_MAX)) begin
      speed_q <= speed_q + 3'd1;
    end
  end

  assign alien_speed = speed_q;
`else
  assign alien_speed = 3'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl
// Self-checking bench for game_ctrl. A behavioural model of the game rules
// (plain integers for state, lives, score and speed) advances on every clock
// edge; a compare process checks every DUT output against it on each falling
// edge. Directed sequences with hand-worked literal expectations come first,
// followed by a long randomized run.
module tb_game_ctrl;

  localparam int LIVES_INIT = 3;
  localparam int HIT_FRAMES = 60;
`ifdef WAVE_SPEEDUP_EN
  localparam logic [7:0] SPEED_AFTER_WAVES = 8'd7;
`else
  localparam logic [7:0] SPEED_AFTER_WAVES = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_shoot = 1'b0;
  logic       btn_rst = 1'b0;
  logic       alien_hit = 1'b0;
  logic       player_hit = 1'b0;
  logic       aliens_landed = 1'b0;
  logic       aliens_cleared = 1'b0;
  logic [1:0] state;
  logic       play_en;
  logic       world_rst;
  logic [1:0] lives;
  logic [7:0] score_bcd;
  logic [2:0] alien_speed;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  game_ctrl #(
    .LIVES_INIT (LIVES_INIT),
    .HIT_FRAMES (HIT_FRAMES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .btn_shoot      (btn_shoot),
    .btn_rst        (btn_rst),
    .alien_hit      (alien_hit),
    .player_hit     (player_hit),
    .aliens_landed  (aliens_landed),
    .aliens_cleared (aliens_cleared),
    .state          (state),
    .play_en        (play_en),
    .world_rst      (world_rst),
    .lives          (lives),
    .score_bcd      (score_bcd),
    .alien_speed    (alien_speed)
  );

  always #5 clk = ~clk;

  // Behavioural model state: state code 0..3, lives, score as a plain
  // integer 0..99, speed index, remaining freeze frames, previous shoot level.
  int m_state, m_lives, m_score, m_speed, m_freeze;
  bit m_prev_shoot, m_wrst, m_edge, m_over;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The game rules applied once per clock to the model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_lives = LIVES_INIT; m_score = 0; m_speed = 0;
      m_freeze = 0; m_prev_shoot = 1'b0; m_wrst = 1'b0;
    end else begin
      m_edge = btn_shoot && !m_prev_shoot;
      m_prev_shoot = btn_shoot;
      m_wrst = 1'b0;
      if (btn_rst) begin
        m_state = 0; m_lives = LIVES_INIT; m_score = 0; m_speed = 0; m_freeze = 0;
      end else if (m_state == 0) begin
        if (m_edge) begin
          m_state = 1; m_lives = LIVES_INIT; m_score = 0; m_speed = 0; m_wrst = 1'b1;
        end
      end else if (m_state == 1) begin
        m_over = aliens_landed || (player_hit && m_lives == 1);
        if (alien_hit && m_score < 99) m_score = m_score + 1;
        if (aliens_landed) begin
          m_lives = 0; m_state = 3;
        end else if (player_hit) begin
          if (m_lives == 1) begin
            m_lives = 0; m_state = 3;
          end else begin
            m_lives = m_lives - 1; m_freeze = HIT_FRAMES; m_state = 2;
          end
        end
        if (aliens_cleared && !m_over) begin
          m_wrst = 1'b1;
`ifdef WAVE_SPEEDUP_EN
          if (m_speed < 7) m_speed = m_speed + 1;
`endif
        end
      end else if (m_state == 2) begin
        if (frame_tick) begin
          m_freeze = m_freeze - 1;
          if (m_freeze == 0) m_state = 1;
        end
      end else begin
        if (m_edge) m_state = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      checkOutput("state",       8'(state),       8'(m_state));
      checkOutput("play_en",     8'(play_en),     8'(m_state == 1));
      checkOutput("world_rst",   8'(world_rst),   8'(m_wrst));
      checkOutput("lives",       8'(lives),       8'(m_lives));
      checkOutput("score_bcd",   score_bcd,       to_bcd(m_score));
      checkOutput("alien_speed", 8'(alien_speed), 8'(m_speed));
    end
  end

  // Drive one cycle of inputs on the falling edge and return just after the
  // following rising edge, where outputs already reflect this cycle.
  task automatic applyStimulus(input bit shoot, input bit brst, input bit ah,
                               input bit ph, input bit land, input bit clr,
                               input bit tick);
    @(negedge clk);
    btn_shoot = shoot; btn_rst = brst; alien_hit = ah; player_hit = ph;
    aliens_landed = land; aliens_cleared = clr; frame_tick = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sitOutFreeze();
    for (int i = 0; i < HIT_FRAMES; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int wr_count;
    bit shoot_lvl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    checkOutput("rst_state",  8'(state),       8'd0);
    checkOutput("rst_lives",  8'(lives),       8'd3);
    checkOutput("rst_score",  score_bcd,       8'h00);
    checkOutput("rst_playen", 8'(play_en),     8'd0);
    checkOutput("rst_wrst",   8'(world_rst),   8'd0);
    checkOutput("rst_speed",  8'(alien_speed), 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_state",  8'(state),     8'd1);
    checkOutput("start_wrst",   8'(world_rst), 8'd1);
    checkOutput("start_lives",  8'(lives),     8'd3);
    checkOutput("start_score",  score_bcd,     8'h00);
    checkOutput("start_playen", 8'(play_en),   8'd1);
    idleCycle();
    checkOutput("start_wrst_drop", 8'(world_rst), 8'd0);

    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("score_12", score_bcd, 8'h12);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("hit_lives",  8'(lives),   8'd2);
    checkOutput("hit_state",  8'(state),   8'd2);
    checkOutput("hit_playen", 8'(play_en), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hit_score_frozen", score_bcd, 8'h12);
    for (int i = 0; i < HIT_FRAMES - 1; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idleCycle();
    end
    checkOutput("hit_59_ticks", 8'(state), 8'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hit_60_ticks",  8'(state),   8'd1);
    checkOutput("hit_resume_en", 8'(play_en), 8'd1);

    for (int i = 0; i < 86; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("score_98", score_bcd, 8'h98);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("score_sat", score_bcd, 8'h99);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("srst_state", 8'(state), 8'd0);
    checkOutput("srst_lives", 8'(lives), 8'd3);
    checkOutput("srst_score", score_bcd, 8'h00);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      sitOutFreeze();
    end
    checkOutput("one_life_lives", 8'(lives), 8'd1);
    checkOutput("one_life_state", 8'(state), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("last_life_lives", 8'(lives), 8'd0);
    checkOutput("last_life_state", 8'(state), 8'd3);
    checkOutput("last_life_score", score_bcd, 8'h01);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("over_to_idle", 8'(state), 8'd0);
    checkOutput("idle_score_hold", score_bcd, 8'h01);

    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("landed_state", 8'(state),     8'd3);
    checkOutput("landed_lives", 8'(lives),     8'd0);
    checkOutput("landed_wrst",  8'(world_rst), 8'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle();
    wr_count = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (world_rst === 1'b1) wr_count++;
      idleCycle();
    end
    checkOutput("wave_wrst_count", 8'(wr_count),   8'd9);
    checkOutput("wave_speed",      8'(alien_speed), SPEED_AFTER_WAVES);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wave_srst_state", 8'(state),       8'd0);
    checkOutput("wave_srst_speed", 8'(alien_speed), 8'd0);
    checkOutput("wave_srst_lives", 8'(lives),       8'd3);

    shoot_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) shoot_lvl = !shoot_lvl;
      applyStimulus(shoot_lvl,
                    $urandom_range(199) == 0,
                    $urandom_range(3) == 0,
                    $urandom_range(11) == 0,
                    $urandom_range(59) == 0,
                    $urandom_range(9) == 0,
                    $urandom_range(1) == 0);
    end

    idleCycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
